// File: rtl/prog_ctr_pkg.sv
// Shared definitions for the program-counter / fetch controller.
//   - pc_state_t    : controller state encoding
//   - PC_W_DEF      : default program-counter width
//   - RESET_VEC_DEF : default reset / idle fetch address
package prog_ctr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_HALT  = 2'd2,
      ST_FAULT = 2'd3
   } pc_state_t;

   localparam int PC_W_DEF      = 10;
   localparam int RESET_VEC_DEF = 0;

endpackage

// File: rtl/prog_ctr_unit_if.sv
// Fetch-control bundle between the decode/control stage and the PC unit.
//   master : decode/control stage (drives redirect controls, reads status)
//   slave  : prog_ctr_unit (reads controls, drives ROM address and status)
// Signals: start, stall, branch, branch_rel, target, offset, call, ret, halt
//          (controls); prog_ctr, running, done, fault (status).
interface prog_ctr_unit_if
   import prog_ctr_pkg::*;
#(
   parameter int PC_W = PC_W_DEF
);
   logic            start;
   logic            stall;
   logic            branch;
   logic            branch_rel;
   logic [PC_W-1:0] target;
   logic [PC_W-1:0] offset;
   logic            call;
   logic            ret;
   logic            halt;
   logic [PC_W-1:0] prog_ctr;
   logic            running;
   logic            done;
   logic            fault;

   modport master (
      output start, stall, branch, branch_rel, target, offset, call, ret, halt,
      input  prog_ctr, running, done, fault
   );

   modport slave (
      input  start, stall, branch, branch_rel, target, offset, call, ret, halt,
      output prog_ctr, running, done, fault
   );
endinterface

// File: rtl/ret_stack.sv
// Return-address LIFO, DEPTH entries of W bits.
//   clk, reset (sync, active-low) : clock / pointer reset
//   clr                           : synchronous pointer clear
//   push, din                     : write din on top
//   pop                           : discard top entry
//   full, empty, top              : status and current top entry
// The parent never pushes when full or pops when empty; the stack relies on it.
module ret_stack #(
   parameter int DEPTH = 4,
   parameter int W     = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] top
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]   sp;
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] top_idx;

   always_ff @(posedge clk) begin
      if (!reset || clr)
         sp <= '0;
      else if (push)
         sp <= sp + (AW+1)'(1);
      else if (pop)
         sp <= sp - (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[sp[AW-1:0]] <= din;
   end

   assign top_idx = sp[AW-1:0] - AW'(1);
   assign top     = mem[top_idx];
   assign full    = (sp == (AW+1)'(DEPTH));
   assign empty   = (sp == '0);
endmodule

// File: rtl/prog_ctr_unit.sv
// Program-counter / instruction-fetch controller.
//   clk   : system clock, rising edge
//   reset : synchronous active-low reset
//   bus   : prog_ctr_unit_if.slave (redirect controls in, ROM address/status out)
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | held at RESET_VEC while start=1; leaves to RUN when start=0
// ST_RUN   | fetching; halt > stall > ret > call > branch > increment
// ST_HALT  | halted by request, PC frozen, sticky until start/reset
// ST_FAULT | return-stack overflow/underflow, PC frozen, sticky
module prog_ctr_unit
   import prog_ctr_pkg::*;
#(
   parameter int              PC_W        = PC_W_DEF,
   parameter logic [PC_W-1:0] RESET_VEC   = PC_W'(RESET_VEC_DEF),
   parameter int              STACK_DEPTH = 4
) (
   input logic             clk,
   input logic             reset,
   prog_ctr_unit_if.slave  bus
);
   pc_state_t       state, state_nxt;
   logic [PC_W-1:0] pc, pc_nxt, pc_inc;
   logic            stk_push, stk_pop, stk_clr;
   logic            stk_full, stk_empty;
   logic [PC_W-1:0] stk_top;

   assign pc_inc = pc + PC_W'(1);

   ret_stack #(
      .DEPTH (STACK_DEPTH),
      .W     (PC_W)
   ) u_ret_stack (
      .clk   (clk),
      .reset (reset),
      .clr   (stk_clr),
      .push  (stk_push),
      .pop   (stk_pop),
      .din   (pc_inc),
      .full  (stk_full),
      .empty (stk_empty),
      .top   (stk_top)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_IDLE;
         pc    <= RESET_VEC;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      stk_push  = 1'b0;
      stk_pop   = 1'b0;
      stk_clr   = 1'b0;
      if (bus.start) begin
         state_nxt = ST_IDLE;
         pc_nxt    = RESET_VEC;
         stk_clr   = 1'b1;
      end else begin
         unique case (state)
            ST_IDLE: begin
               state_nxt = ST_RUN;
               pc_nxt    = RESET_VEC;
            end
            ST_RUN: begin
               if (bus.halt) begin
                  state_nxt = ST_HALT;
               end else if (bus.stall) begin
                  pc_nxt = pc;
               end else if (bus.ret) begin
                  if (stk_empty) begin
                     state_nxt = ST_FAULT;
                  end else begin
                     pc_nxt  = stk_top;
                     stk_pop = 1'b1;
                  end
               end else if (bus.call) begin
                  if (stk_full) begin
                     state_nxt = ST_FAULT;
                  end else begin
                     pc_nxt   = bus.target;
                     stk_push = 1'b1;
                  end
               end else if (bus.branch) begin
                  pc_nxt = bus.branch_rel ? (pc + bus.offset) : bus.target;
               end else begin
                  pc_nxt = pc_inc;
               end
            end
            ST_HALT, ST_FAULT: begin
               state_nxt = state;
            end
            default: begin
               state_nxt = ST_IDLE;
               pc_nxt    = RESET_VEC;
            end
         endcase
      end
   end

   always_comb begin
      bus.running = (state == ST_RUN);
      bus.done    = (state == ST_HALT) || (state == ST_FAULT);
      bus.fault   = (state == ST_FAULT);
   end

   assign bus.prog_ctr = pc;
endmodule

// File: tb/tb_prog_ctr_unit.sv
module tb_prog_ctr_unit;
   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   prog_ctr_unit_if #(.PC_W(10)) bus ();

   prog_ctr_unit #(
      .PC_W        (10),
      .RESET_VEC   (10'h000),
      .STACK_DEPTH (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctl();
      bus.start = 1'b0; bus.stall = 1'b0; bus.branch = 1'b0; bus.branch_rel = 1'b0;
      bus.target = '0; bus.offset = '0; bus.call = 1'b0; bus.ret = 1'b0; bus.halt = 1'b0;
   endtask

   task automatic goto_pc(input logic [9:0] a);
      clear_ctl(); bus.branch = 1'b1; bus.target = a;
      tick(); clear_ctl();
   endtask

   task automatic restart();
      clear_ctl(); bus.start = 1'b1; tick();
      bus.start = 1'b0; tick();
   endtask

   task automatic test_reset();
      reset = 1'b0; clear_ctl(); bus.start = 1'b1;
      tick(); tick();
      n_checks++; if (bus.prog_ctr !== 10'h000) begin $display("FAIL rst_pc got %h want 000", bus.prog_ctr); n_fail++; end
      n_checks++; if ({bus.running, bus.done, bus.fault} !== 3'b000) begin $display("FAIL rst_flags got %b want 000", {bus.running, bus.done, bus.fault}); n_fail++; end
      reset = 1'b1; tick();
      n_checks++; if ({bus.prog_ctr, bus.running} !== {10'h000, 1'b0}) begin $display("FAIL idle_hold got %h/%b want 000/0", bus.prog_ctr, bus.running); n_fail++; end
      bus.start = 1'b0; tick();
      n_checks++; if ({bus.prog_ctr, bus.running} !== {10'h000, 1'b1}) begin $display("FAIL first_fetch got %h/%b want 000/1", bus.prog_ctr, bus.running); n_fail++; end
      tick();
      n_checks++; if (bus.prog_ctr !== 10'h001) begin $display("FAIL inc1 got %h want 001", bus.prog_ctr); n_fail++; end
      tick();
      n_checks++; if (bus.prog_ctr !== 10'h002) begin $display("FAIL inc2 got %h want 002", bus.prog_ctr); n_fail++; end
   endtask

   task automatic test_branch();
      goto_pc(10'h010);
      n_checks++; if (bus.prog_ctr !== 10'h010) begin $display("FAIL br_setup got %h want 010", bus.prog_ctr); n_fail++; end
      goto_pc(10'h008);
      n_checks++; if (bus.prog_ctr !== 10'h008) begin $display("FAIL br_abs got %h want 008", bus.prog_ctr); n_fail++; end
      bus.branch = 1'b1; bus.branch_rel = 1'b1; bus.offset = 10'h3FC; bus.target = 10'h2AA;
      tick(); clear_ctl();
      n_checks++; if (bus.prog_ctr !== 10'h004) begin $display("FAIL br_rel_neg got %h want 004", bus.prog_ctr); n_fail++; end
      goto_pc(10'h3FF);
      tick();
      n_checks++; if (bus.prog_ctr !== 10'h000) begin $display("FAIL inc_wrap got %h want 000", bus.prog_ctr); n_fail++; end
      goto_pc(10'h3FE);
      bus.branch = 1'b1; bus.branch_rel = 1'b1; bus.offset = 10'h005;
      tick(); clear_ctl();
      n_checks++; if (bus.prog_ctr !== 10'h003) begin $display("FAIL br_rel_wrap got %h want 003", bus.prog_ctr); n_fail++; end
      n_checks++; if ({bus.running, bus.fault} !== 2'b10) begin $display("FAIL wrap_nofault got %b want 10", {bus.running, bus.fault}); n_fail++; end
   endtask

   task automatic test_call_ret();
      goto_pc(10'h020);
      bus.call = 1'b1; bus.target = 10'h100; tick(); clear_ctl();
      n_checks++; if (bus.prog_ctr !== 10'h100) begin $display("FAIL call got %h want 100", bus.prog_ctr); n_fail++; end
      tick(); tick(); tick();
      n_checks++; if (bus.prog_ctr !== 10'h103) begin $display("FAIL callee_run got %h want 103", bus.prog_ctr); n_fail++; end
      bus.ret = 1'b1; tick(); clear_ctl();
      n_checks++; if (bus.prog_ctr !== 10'h021) begin $display("FAIL ret got %h want 021", bus.prog_ctr); n_fail++; end
      bus.call = 1'b1; bus.target = 10'h200; tick(); clear_ctl();
      bus.ret = 1'b1; tick(); clear_ctl();
      n_checks++; if (bus.prog_ctr !== 10'h022) begin $display("FAIL ret_after_call got %h want 022", bus.prog_ctr); n_fail++; end
      goto_pc(10'h300);
      bus.call = 1'b1; bus.target = 10'h310; tick();
      bus.target = 10'h320; tick(); clear_ctl();
      bus.ret = 1'b1; tick();
      n_checks++; if (bus.prog_ctr !== 10'h311) begin $display("FAIL lifo_inner got %h want 311", bus.prog_ctr); n_fail++; end
      tick(); clear_ctl();
      n_checks++; if (bus.prog_ctr !== 10'h301) begin $display("FAIL lifo_outer got %h want 301", bus.prog_ctr); n_fail++; end
      bus.call = 1'b1; bus.branch = 1'b1; bus.branch_rel = 1'b1; bus.offset = 10'h010; bus.target = 10'h050;
      tick(); clear_ctl();
      n_checks++; if (bus.prog_ctr !== 10'h050) begin $display("FAIL call_over_branch got %h want 050", bus.prog_ctr); n_fail++; end
      bus.ret = 1'b1; tick(); clear_ctl();
      n_checks++; if (bus.prog_ctr !== 10'h302) begin $display("FAIL ret_cob got %h want 302", bus.prog_ctr); n_fail++; end
      goto_pc(10'h3FF);
      bus.call = 1'b1; bus.target = 10'h010; tick(); clear_ctl();
      bus.ret = 1'b1; tick(); clear_ctl();
      n_checks++; if (bus.prog_ctr !== 10'h000) begin $display("FAIL ret_wrap got %h want 000", bus.prog_ctr); n_fail++; end
      // stack is empty again: Ret beats Call and underflows
      bus.call = 1'b1; bus.ret = 1'b1; bus.target = 10'h123; tick(); clear_ctl();
      n_checks++; if ({bus.fault, bus.prog_ctr} !== {1'b1, 10'h000}) begin $display("FAIL ret_over_call got %b/%h want 1/000", bus.fault, bus.prog_ctr); n_fail++; end
   endtask

   task automatic test_stack_fault();
      logic [9:0] tgt [5];
      tgt[0] = 10'h040; tgt[1] = 10'h080; tgt[2] = 10'h0C0; tgt[3] = 10'h100; tgt[4] = 10'h140;
      restart();
      n_checks++; if ({bus.running, bus.fault, bus.prog_ctr} !== {1'b1, 1'b0, 10'h000}) begin $display("FAIL recover1 got %b%b/%h want 10/000", bus.running, bus.fault, bus.prog_ctr); n_fail++; end
      for (int i = 0; i < 4; i++) begin
         bus.call = 1'b1; bus.target = tgt[i]; tick();
      end
      clear_ctl();
      n_checks++; if ({bus.fault, bus.prog_ctr} !== {1'b0, 10'h100}) begin $display("FAIL four_calls got %b/%h want 0/100", bus.fault, bus.prog_ctr); n_fail++; end
      bus.call = 1'b1; bus.target = tgt[4]; tick(); clear_ctl();
      n_checks++; if ({bus.fault, bus.done, bus.running, bus.prog_ctr} !== {3'b110, 10'h100}) begin $display("FAIL overflow got %b%b%b/%h want 110/100", bus.fault, bus.done, bus.running, bus.prog_ctr); n_fail++; end
      bus.branch = 1'b1; bus.target = 10'h2AA; bus.ret = 1'b1; tick(); tick(); tick(); clear_ctl();
      n_checks++; if ({bus.fault, bus.prog_ctr} !== {1'b1, 10'h100}) begin $display("FAIL fault_sticky got %b/%h want 1/100", bus.fault, bus.prog_ctr); n_fail++; end
      restart();
      bus.ret = 1'b1; tick(); clear_ctl();
      n_checks++; if ({bus.fault, bus.done, bus.prog_ctr} !== {2'b11, 10'h000}) begin $display("FAIL underflow got %b%b/%h want 11/000", bus.fault, bus.done, bus.prog_ctr); n_fail++; end
      bus.start = 1'b1; tick();
      n_checks++; if ({bus.running, bus.done, bus.fault} !== 3'b000) begin $display("FAIL start_clears got %b want 000", {bus.running, bus.done, bus.fault}); n_fail++; end
      bus.start = 1'b0; tick(); tick();
      n_checks++; if ({bus.running, bus.prog_ctr} !== {1'b1, 10'h001}) begin $display("FAIL recover2 got %b/%h want 1/001", bus.running, bus.prog_ctr); n_fail++; end
   endtask

   task automatic test_stall_halt();
      goto_pc(10'h005);
      bus.stall = 1'b1; bus.branch = 1'b1; bus.target = 10'h3AA;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if (bus.prog_ctr !== 10'h005) begin $display("FAIL stall_hold[%0d] got %h want 005", i, bus.prog_ctr); n_fail++; end
      end
      clear_ctl(); tick();
      n_checks++; if (bus.prog_ctr !== 10'h006) begin $display("FAIL stall_release got %h want 006", bus.prog_ctr); n_fail++; end
      bus.halt = 1'b1; tick(); clear_ctl();
      n_checks++; if ({bus.done, bus.running, bus.fault} !== 3'b100) begin $display("FAIL halt_flags got %b want 100", {bus.done, bus.running, bus.fault}); n_fail++; end
      bus.branch = 1'b1; bus.target = 10'h155; bus.call = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_checks++; if ({bus.done, bus.prog_ctr} !== {1'b1, 10'h006}) begin $display("FAIL halt_hold[%0d] got %b/%h want 1/006", i, bus.done, bus.prog_ctr); n_fail++; end
      end
      clear_ctl();
   endtask

   task automatic test_reset_mid();
      restart();
      goto_pc(10'h0A7);
      n_checks++; if (bus.prog_ctr !== 10'h0A7) begin $display("FAIL mid_setup got %h want 0a7", bus.prog_ctr); n_fail++; end
      bus.call = 1'b1; bus.target = 10'h111; tick();
      bus.target = 10'h222; reset = 1'b0; tick();
      n_checks++; if ({bus.prog_ctr, bus.running, bus.done} !== {10'h000, 2'b00}) begin $display("FAIL mid_reset got %h/%b%b want 000/00", bus.prog_ctr, bus.running, bus.done); n_fail++; end
      reset = 1'b1; clear_ctl(); tick();
      n_checks++; if ({bus.prog_ctr, bus.running} !== {10'h000, 1'b1}) begin $display("FAIL mid_resume got %h/%b want 000/1", bus.prog_ctr, bus.running); n_fail++; end
      bus.ret = 1'b1; tick(); tick(); clear_ctl();
      n_checks++; if (bus.fault !== 1'b1) begin $display("FAIL mid_stack_empty got %b want 1", bus.fault); n_fail++; end
   endtask

   initial begin
      reset = 1'b0;
      clear_ctl();
      test_reset();
      test_branch();
      test_call_ret();
      test_stack_fault();
      test_stall_halt();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
